dark_channel_win: RTL and testbench
===================================

Name: dark_channel_win

Overview:
- Streaming dark-channel extractor with parameterised window, data width and image size; successor to the fixed 3x3 dark-channel stage in the dehaze pipeline.
- Per pixel: min(R,G,B), then min over a WIN x WIN window whose bottom-right corner is the current pixel.
- Owns its line buffers; adds valid/frame-sync handshake and image-border padding.
- Output feeds the atmospheric-light and transmission stages.

Parameters:
- DATA_W, 8, bits per colour channel and per dark-channel output.
- WIN, 3, window size; odd, legal 3..7.
- IMG_W, 640, active pixels per line.
- IMG_H, 480, active lines per frame.

Ports:
- sys_clk, input, 1, single clock, rising edge.
- sys_rst_n, input, 1, asynchronous active-low reset.
- in_valid, input, 1, pixel qualifier; no backpressure.
- in_sof, input, 1, start of frame; sampled only with in_valid.
- in_data, input, 3*DATA_W, packed {R,G,B}; R in the MSBs.
- out_valid, output, 1, output pixel qualifier.
- out_sof, output, 1, marks the first output pixel of a frame.
- out_dark, output, DATA_W, dark-channel value.

Behaviour:
- Reset (asynchronous, sys_rst_n=0):
  - out_valid, out_sof and out_dark are 0.
  - Column and row counters are 0.
  - Horizontal shift register is set to all-ones.
  - Line-buffer contents need no reset; masking covers them.
- Accept: a pixel is accepted on every sys_clk edge with in_valid=1. When in_valid=0 the pipeline holds: no counter, buffer or shift-register update.
- Counters:
  - col runs 0..IMG_W-1; row increments when col wraps.
  - After row IMG_H-1, col IMG_W-1, both wrap to 0; the next frame starts even without in_sof.
  - in_sof=1 with in_valid forces col=0, row=0 for that pixel, including mid-frame.
- Stage 0 (accept cycle):
  - Compute rgb_min = min(R,G,B); ties are irrelevant.
  - Issue line-buffer reads at address col.
  - Write rgb_min into line 0 at col; shift line k into line k+1 at col (read-before-write).
- Stage 1 (registered): hold rgb_min, col, row, sof and the WIN-1 line reads.
- Vertical min:
  - Min of stage-1 rgb_min and line k (k=1..WIN-1).
  - Line k is replaced by all-ones when row<k (above the image top).
- Horizontal min:
  - Min of the current vertical min and the shift register of the previous WIN-1 column mins.
  - Entry j (j=1..WIN-1) is replaced by all-ones when col<j (left of the image edge).
  - The shift register advances only on valid stage-1 data.
- Output register: out_dark, out_valid and out_sof update exactly 2 cycles after the accept edge, with fixed latency regardless of in_valid gaps.
- Throughput: one pixel per clock. Output count equals input count. No ready signal; upstream must not exceed 1 pixel/clk.
- Width: all arithmetic is DATA_W unsigned compares; no widening.
- in_sof mid-frame: the frame restarts cleanly, because stale line data is masked by row.
- Reset mid-frame: the in-flight 2 pixels are dropped; the first pixel after reset is treated as row 0, col 0.

Optional Feature:
- Macro: DC_ATMOS_MAX_EN.
- Defined:
  - Adds outputs atmos_max (DATA_W) and atmos_valid (1).
  - Tracks the running max of out_dark over the frame; the running max is cleared when out_sof is issued.
  - One cycle after the output of pixel (IMG_H-1, IMG_W-1), atmos_valid pulses for 1 cycle and atmos_max holds the frame max until the next pulse.
  - Both outputs reset to 0.
- Undefined: these ports and this logic are absent.

Decomposition:
- Package dc_pkg holds:
  - Width and count helpers (COL_W=$clog2(IMG_W), ROW_W=$clog2(IMG_H)).
  - The all-ones pad constant.
  - A min2 function.
- Sub-module dc_line_buf: one IMG_W x DATA_W, single-port, synchronous-read, read-before-write line memory. dark_channel_win instantiates WIN-1 copies, chained.

Test Plan (IMG_W=8, IMG_H=4, WIN=3, DATA_W=8 unless stated):
- Flat frame, all pixels {50,30,40} -> every out_dark=30; out_sof on the first output; latency 2 cycles.
- Single dark pixel {5,5,5} at (row1,col2), rest 100 -> out_dark=5 at (1..3, 2..4), 100 elsewhere; row 0 and cols 0..1 are unaffected.
- Border: pixel (0,0)=7, rest 200 -> outputs (0,0),(0,1),(0,2),(1,0),(2,2)=7; (3,3)=200; no wrap from the previous line end.
- in_valid toggled 1,0,0,1 through the whole frame -> identical out_dark sequence to the gapless run; each output exactly 2 clocks after its input.
- in_sof asserted at frame pixel 13, then 0 elsewhere -> the pixel at sof is treated as (0,0), no old-frame values leak, and out_sof appears 2 cycles later. Also: reset asserted mid-line -> outputs 0 immediately; the next frame is correct.
- DC_ATMOS_MAX_EN defined, frame max dark value 180 -> atmos_valid single pulse 1 cycle after the last output, atmos_max=180; the next frame with max 60 reports 60.

Source files
------------

// File: rtl/dc_pkg.sv
// Shared helpers for the dark-channel stage: counter widths, all-ones pad value, unsigned min.
// DATA_W of the users must not exceed DC_MAX_W.
package dc_pkg;

   localparam int DC_MAX_W = 16;
   localparam logic [DC_MAX_W-1:0] PAD_ONES = '1;

   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic logic [DC_MAX_W-1:0] min2(input logic [DC_MAX_W-1:0] a,
                                                input logic [DC_MAX_W-1:0] b);
      return (a < b) ? a : b;
   endfunction

endpackage

// File: rtl/dc_line_buf.sv
// One image line of storage: single address, read-before-write, registered read data.
// old_data exposes the pre-write word so the next line in the chain can take it this cycle.
module dc_line_buf #(
   parameter int DEPTH  = 640,
   parameter int DATA_W = 8,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              en,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] old_data,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   assign old_data = mem[addr];

   always_ff @(posedge clk) begin
      if (en) begin
         rdata     <= mem[addr];
         mem[addr] <= wdata;
      end
   end

endmodule

// File: rtl/dark_channel_win.sv
// Streaming WIN x WIN dark channel (min RGB, then window min), 2-cycle latency, no backpressure.
// Defining DC_ATMOS_MAX_EN adds the per-frame atmos_max / atmos_valid outputs.
module dark_channel_win
   import dc_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int WIN    = 3,
   parameter int IMG_W  = 640,
   parameter int IMG_H  = 480
) (
   input  logic                sys_clk,
   input  logic                sys_rst_n,
   input  logic                in_valid,
   input  logic                in_sof,
   input  logic [3*DATA_W-1:0] in_data,
   output logic                out_valid,
   output logic                out_sof,
   output logic [DATA_W-1:0]   out_dark
`ifdef DC_ATMOS_MAX_EN
   ,
   output logic [DATA_W-1:0]   atmos_max,
   output logic                atmos_valid
`endif
);

   localparam int COL_W = cnt_w(IMG_W);
   localparam int ROW_W = cnt_w(IMG_H);
   localparam int NL    = WIN - 1;
   localparam logic [DATA_W-1:0] PAD = DATA_W'(PAD_ONES);

   function automatic logic [DATA_W-1:0] dmin(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b);
      return DATA_W'(min2(DC_MAX_W'(a), DC_MAX_W'(b)));
   endfunction

   logic [COL_W-1:0]  col, pix_col, s0_col, s1_col;
   logic [ROW_W-1:0]  row, pix_row, s0_row, s1_row;
   logic [DATA_W-1:0] px_r, px_g, px_b, rgb_min, s0_min, s1_min;
   logic              s0_vld, s0_sof, s1_vld, s1_sof;
   logic [DATA_W-1:0] lb_wdata [1:NL];
   logic [DATA_W-1:0] lb_old   [1:NL];
   logic [DATA_W-1:0] lb_rdata [1:NL];
   logic [DATA_W-1:0] s1_line  [1:NL];
   logic [DATA_W-1:0] hsr      [1:NL];
   logic [DATA_W-1:0] vmin, hmin;
   logic              unused_tail;

   assign pix_col = in_sof ? '0 : col;
   assign pix_row = in_sof ? '0 : row;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         col <= '0;
         row <= '0;
      end else if (in_valid) begin
         if (pix_col == COL_W'(IMG_W - 1)) begin
            col <= '0;
            row <= (pix_row == ROW_W'(IMG_H - 1)) ? '0 : pix_row + 1'b1;
         end else begin
            col <= pix_col + 1'b1;
            row <= pix_row;
         end
      end
   end

   assign {px_r, px_g, px_b} = in_data;
   assign rgb_min = dmin(dmin(px_r, px_g), px_b);

   // Line k holds row-k; each line hands its old word down to the next on the same access.
   for (genvar k = 1; k <= NL; k++) begin : g_lb
      if (k == 1) begin : g_head
         assign lb_wdata[k] = rgb_min;
      end else begin : g_chain
         assign lb_wdata[k] = lb_old[k-1];
      end
      dc_line_buf #(.DEPTH(IMG_W), .DATA_W(DATA_W), .ADDR_W(COL_W)) u_lb (
         .clk      (sys_clk),
         .en       (in_valid),
         .addr     (pix_col),
         .wdata    (lb_wdata[k]),
         .old_data (lb_old[k]),
         .rdata    (lb_rdata[k])
      );
   end
   assign unused_tail = ^lb_old[NL];

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         s0_vld <= 1'b0;
         s0_sof <= 1'b0;
         s0_min <= '0;
         s0_col <= '0;
         s0_row <= '0;
         s1_vld <= 1'b0;
         s1_sof <= 1'b0;
         s1_min <= '0;
         s1_col <= '0;
         s1_row <= '0;
         for (int k = 1; k <= NL; k++) s1_line[k] <= '0;
      end else begin
         s0_vld <= in_valid;
         if (in_valid) begin
            s0_sof <= in_sof;
            s0_min <= rgb_min;
            s0_col <= pix_col;
            s0_row <= pix_row;
         end
         s1_vld <= s0_vld;
         s1_sof <= s0_sof;
         s1_min <= s0_min;
         s1_col <= s0_col;
         s1_row <= s0_row;
         for (int k = 1; k <= NL; k++) s1_line[k] <= lb_rdata[k];
      end
   end

   // Rows above the top and columns left of the edge read as all-ones so they never win.
   always_comb begin
      vmin = s1_min;
      for (int k = 1; k <= NL; k++)
         vmin = dmin(vmin, (int'(s1_row) < k) ? PAD : s1_line[k]);
      hmin = vmin;
      for (int j = 1; j <= NL; j++)
         hmin = dmin(hmin, (int'(s1_col) < j) ? PAD : hsr[j]);
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         for (int j = 1; j <= NL; j++) hsr[j] <= PAD;
         out_valid <= 1'b0;
         out_sof   <= 1'b0;
         out_dark  <= '0;
      end else begin
         if (s1_vld) begin
            hsr[1] <= vmin;
            for (int j = 2; j <= NL; j++) hsr[j] <= hsr[j-1];
            out_dark <= hmin;
         end
         out_valid <= s1_vld;
         out_sof   <= s1_vld & s1_sof;
      end
   end

`ifdef DC_ATMOS_MAX_EN
   logic [DATA_W-1:0] run_max;
   logic              last_out;

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         run_max     <= '0;
         last_out    <= 1'b0;
         atmos_max   <= '0;
         atmos_valid <= 1'b0;
      end else begin
         last_out <= s1_vld && (s1_col == COL_W'(IMG_W - 1)) && (s1_row == ROW_W'(IMG_H - 1));
         if (s1_vld)
            run_max <= (s1_sof || (hmin > run_max)) ? hmin : run_max;
         atmos_valid <= last_out;
         if (last_out)
            atmos_max <= run_max;
      end
   end
`endif

endmodule

// File: tb/tb_dark_channel_win.sv
// Directed bench for dark_channel_win on an 8x4 image with a 3x3 window.
// Expected window values come from a brute-force min over the stored frame.
module tb_dark_channel_win;

   localparam int DW   = 8;
   localparam int W    = 8;
   localparam int H    = 4;
   localparam int WN   = 3;
   localparam int NPIX = W * H;

   logic              sys_clk = 1'b0;
   logic              sys_rst_n = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_sof = 1'b0;
   logic [3*DW-1:0]   in_data = '0;
   logic              out_valid;
   logic              out_sof;
   logic [DW-1:0]     out_dark;
`ifdef DC_ATMOS_MAX_EN
   logic [DW-1:0]     atmos_max;
   logic              atmos_valid;
`endif

   int n_pass = 0;
   int n_fail = 0;
   int n_chk  = 0;
   int cyc    = 0;

   logic [3*DW-1:0] img [NPIX];
   int              in_cyc[$];
   int              out_cyc[$];
   logic [DW-1:0]   obs[$];
   logic            obs_sof[$];
   int              at_cyc[$];
   logic [DW-1:0]   at_val[$];

   dark_channel_win #(.DATA_W(DW), .WIN(WN), .IMG_W(W), .IMG_H(H)) dut (
      .sys_clk     (sys_clk),
      .sys_rst_n   (sys_rst_n),
      .in_valid    (in_valid),
      .in_sof      (in_sof),
      .in_data     (in_data),
      .out_valid   (out_valid),
      .out_sof     (out_sof),
      .out_dark    (out_dark)
`ifdef DC_ATMOS_MAX_EN
      ,
      .atmos_max   (atmos_max),
      .atmos_valid (atmos_valid)
`endif
   );

   always #5 sys_clk = ~sys_clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      assert (got === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int rgbmin(input logic [23:0] p);
      int m;
      m = int'(p[23:16]);
      if (int'(p[15:8]) < m) m = int'(p[15:8]);
      if (int'(p[7:0]) < m) m = int'(p[7:0]);
      return m;
   endfunction

   function automatic int ref_dark(input int idx);
      int r, c, m;
      r = idx / W;
      c = idx % W;
      m = 255;
      for (int dr = 0; dr < WN; dr++)
         for (int dc = 0; dc < WN; dc++)
            if (r - dr >= 0 && c - dc >= 0 && rgbmin(img[(r-dr)*W + c - dc]) < m)
               m = rgbmin(img[(r-dr)*W + c - dc]);
      return m;
   endfunction

   task automatic clear_q();
      in_cyc.delete();
      out_cyc.delete();
      obs.delete();
      obs_sof.delete();
      at_cyc.delete();
      at_val.delete();
   endtask

   task automatic step(input logic v, input logic s, input logic [3*DW-1:0] d);
      in_valid = v;
      in_sof   = s;
      in_data  = d;
      if (v) in_cyc.push_back(cyc + 1);
      @(posedge sys_clk);
      #1;
      cyc++;
      if (out_valid) begin
         obs.push_back(out_dark);
         obs_sof.push_back(out_sof);
         out_cyc.push_back(cyc);
      end
`ifdef DC_ATMOS_MAX_EN
      if (atmos_valid) begin
         at_cyc.push_back(cyc);
         at_val.push_back(atmos_max);
      end
`endif
   endtask

   task automatic run_frame(input logic gap, input logic sof0);
      for (int i = 0; i < NPIX; i++) begin
         step(1'b1, sof0 && (i == 0), img[i]);
         if (gap) begin
            step(1'b0, 1'b0, '0);
            step(1'b0, 1'b0, '0);
         end
      end
      repeat (4) step(1'b0, 1'b0, '0);
   endtask

   task automatic check_frame(input string tag, input int base, input logic sof0);
      chk({tag, " count"}, obs.size(), base + NPIX);
      if (obs.size() == base + NPIX && in_cyc.size() == base + NPIX) begin
         for (int i = 0; i < NPIX; i++) begin
            chk($sformatf("%s dark%0d", tag, i), obs[base+i], ref_dark(i));
            chk($sformatf("%s lat%0d", tag, i), out_cyc[base+i] - in_cyc[base+i], 2);
            chk($sformatf("%s sof%0d", tag, i), obs_sof[base+i], (i == 0) ? sof0 : 1'b0);
         end
      end
   endtask

   task automatic chk_idx(input string tag, input int idx, input int exp);
      logic [31:0] v;
      v = (idx < obs.size()) ? 32'(obs[idx]) : 'x;
      chk(tag, v, exp);
   endtask

   task automatic load_dot();
      for (int i = 0; i < NPIX; i++) img[i] = 24'h646464;
      img[1*W + 2] = 24'h050505;
   endtask

   initial begin
      // reset state
      #3;
      chk("rst out_valid", out_valid, 0);
      chk("rst out_sof", out_sof, 0);
      chk("rst out_dark", out_dark, 0);
`ifdef DC_ATMOS_MAX_EN
      chk("rst atmos_valid", atmos_valid, 0);
      chk("rst atmos_max", atmos_max, 0);
`endif
      @(posedge sys_clk);
      #1;
      sys_rst_n = 1'b1;

      // flat frame {50,30,40}
      for (int i = 0; i < NPIX; i++) img[i] = {8'd50, 8'd30, 8'd40};
      clear_q();
      run_frame(1'b0, 1'b1);
      check_frame("flat", 0, 1'b1);
      chk_idx("flat px0", 0, 30);
      chk_idx("flat px31", 31, 30);

      // single dark pixel at (1,2)
      load_dot();
      clear_q();
      run_frame(1'b0, 1'b1);
      check_frame("dot", 0, 1'b1);
      chk_idx("dot (1,2)", 10, 5);
      chk_idx("dot (2,4)", 20, 5);
      chk_idx("dot (3,4)", 28, 5);
      chk_idx("dot (1,1)", 9, 100);
      chk_idx("dot (0,2)", 2, 100);
      chk_idx("dot (3,5)", 29, 100);

      // top-left border
      for (int i = 0; i < NPIX; i++) img[i] = 24'hC8C8C8;
      img[0] = {8'd7, 8'd9, 8'd8};
      clear_q();
      run_frame(1'b0, 1'b1);
      check_frame("border", 0, 1'b1);
      chk_idx("border (0,0)", 0, 7);
      chk_idx("border (0,2)", 2, 7);
      chk_idx("border (1,0)", 8, 7);
      chk_idx("border (2,2)", 18, 7);
      chk_idx("border (0,3)", 3, 200);
      chk_idx("border (3,0)", 24, 200);
      chk_idx("border (3,3)", 27, 200);

      // in_valid pattern 1,0,0 repeated
      load_dot();
      clear_q();
      run_frame(1'b1, 1'b1);
      check_frame("gap", 0, 1'b1);
      chk_idx("gap (1,2)", 10, 5);
      chk_idx("gap (1,1)", 9, 100);

      // sof at frame pixel 13 restarts the frame
      clear_q();
      for (int i = 0; i < 13; i++) step(1'b1, i == 0, 24'h030303);
      for (int i = 0; i < NPIX; i++) img[i] = 24'h969696;
      img[2*W + 5] = 24'h141E28;
      run_frame(1'b0, 1'b1);
      check_frame("sof13", 13, 1'b1);
      chk_idx("sof13 new (0,0)", 13, 150);
      chk_idx("sof13 new (1,0)", 13 + 8, 150);
      chk_idx("sof13 new (2,5)", 13 + 21, 20);
      chk_idx("sof13 old px0", 0, 3);

      // reset in the middle of a line
      clear_q();
      for (int i = 0; i < 5; i++) step(1'b1, i == 0, 24'h646464);
      chk("pre-reset out_valid", out_valid, 1);
      chk("pre-reset out_dark", out_dark, 100);
      in_valid = 1'b0;
      in_sof   = 1'b0;
      #2;
      sys_rst_n = 1'b0;
      #1;
      chk("mid-reset out_valid", out_valid, 0);
      chk("mid-reset out_sof", out_sof, 0);
      chk("mid-reset out_dark", out_dark, 0);
      @(posedge sys_clk);
      #1;
      sys_rst_n = 1'b1;
      load_dot();
      clear_q();
      run_frame(1'b0, 1'b0);
      check_frame("post-reset", 0, 1'b0);
      chk_idx("post-reset (1,2)", 10, 5);

`ifdef DC_ATMOS_MAX_EN
      // running frame max
      for (int i = 0; i < NPIX; i++) img[i] = {8'd200, 8'd180, 8'd190};
      clear_q();
      run_frame(1'b0, 1'b1);
      chk("atmos180 pulses", at_val.size(), 1);
      if (at_val.size() == 1 && out_cyc.size() == NPIX) begin
         chk("atmos180 value", at_val[0], 180);
         chk("atmos180 timing", at_cyc[0], out_cyc[NPIX-1] + 1);
      end
      chk("atmos180 held", atmos_max, 180);
      for (int i = 0; i < NPIX; i++) img[i] = {8'd60, 8'd70, 8'd80};
      clear_q();
      run_frame(1'b0, 1'b1);
      chk("atmos60 pulses", at_val.size(), 1);
      if (at_val.size() == 1)
         chk("atmos60 value", at_val[0], 60);
      chk("atmos60 held", atmos_max, 60);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
